// File: rtl/param_divider.sv
// param_divider: sequential unsigned divider, DW-bit dividend by VW-bit
// divisor, producing a QW = DW-VW bit quotient and a VW-bit remainder.
// One quotient bit per cycle, restoring or non-restoring selected per request.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      request (sampled in IDLE only) with mode/dividend/divisor
//   mode       0 = restoring, 1 = non-restoring
//   dividend   DW-bit unsigned dividend
//   divisor    VW-bit unsigned divisor
//   gotResult  consumer acknowledge, releases DONE
//   busy       high in LOAD, CALC, FIX
//   done       high in DONE
//   Q, R       quotient / remainder (held until next LOAD / FIX)
//   divByZero  divisor was zero
//   ov         quotient would not fit in QW bits
module param_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [DW-1:0]    dividend,
  input  logic [VW-1:0]    divisor,
  input  logic             gotResult,
  output logic             busy,
  output logic             done,
  output logic [DW-VW-1:0] Q,
  output logic [VW-1:0]    R,
  output logic             divByZero,
  output logic             ov
);
  localparam int QW = DW - VW;
  localparam int CW = $clog2(QW + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CALC, FIX, DONE} state_t;
  state_t state, nstate;

  logic [DW-1:0] dvd_r;
  logic [VW-1:0] dvs_r;
  logic          mode_r;
  logic [VW:0]   a;      // partial remainder, two's complement
  logic [QW-1:0] q;      // quotient shift register, drives Q directly
  logic [CW-1:0] cnt;

  logic          err;
  logic [VW:0]   dvs_x, a_sh, a_sub, a_add, a_nxt;
  logic          qbit;

  // Quotient overflows whenever the upper dividend half is not below divisor.
  assign err = (dvs_r == '0) || (dvd_r[DW-1:QW] >= dvs_r);

  // One iteration. The shifted value may exceed the VW+1 signed range, but
  // the add/sub result always lies in [-d, d) so modular arithmetic is exact.
  always_comb begin
    dvs_x = {1'b0, dvs_r};
    a_sh  = {a[VW-1:0], q[QW-1]};
    a_sub = a_sh - dvs_x;
    a_add = a_sh + dvs_x;
    if (mode_r) begin
      a_nxt = a[VW] ? a_add : a_sub;
      qbit  = ~a_nxt[VW];
    end else begin
      a_nxt = a_sub[VW] ? a_sh : a_sub;
      qbit  = ~a_sub[VW];
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE: if (start) nstate = LOAD;
      LOAD: nstate = err ? DONE : CALC;
      CALC: if (cnt == CW'(QW - 1)) nstate = FIX;
      FIX:  nstate = DONE;
      DONE: if (gotResult) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_r     <= '0;
      dvs_r     <= '0;
      mode_r    <= 1'b0;
      a         <= '0;
      q         <= '0;
      R         <= '0;
      cnt       <= '0;
      divByZero <= 1'b0;
      ov        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd_r  <= dividend;
          dvs_r  <= divisor;
          mode_r <= mode;
        end
        LOAD: begin
          divByZero <= 1'b0;
          ov        <= 1'b0;
          cnt       <= '0;
          if (err) begin
            divByZero <= (dvs_r == '0);
            ov        <= (dvs_r != '0);
            q         <= '1;
            R         <= '0;
          end else begin
            a <= {1'b0, dvd_r[DW-1:QW]};
            q <= dvd_r[QW-1:0];
          end
        end
        CALC: begin
          a   <= a_nxt;
          q   <= {q[QW-2:0], qbit};
          cnt <= cnt + 1'b1;
        end
        // Only the low VW bits are kept, so a VW-bit correction add suffices.
        FIX: R <= (mode_r && a[VW]) ? (a[VW-1:0] + dvs_r) : a[VW-1:0];
        default: ;
      endcase
    end
  end

  assign Q    = q;
  assign busy = (state == LOAD) || (state == CALC) || (state == FIX);
  assign done = (state == DONE);

endmodule

// File: tb/tb_param_divider.sv
module tb_param_divider;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        gotResult = 1'b0;
  logic        busy, done, divByZero, ov;
  logic [7:0]  Q, R;

  int nchk = 0;
  int nfail = 0;

  param_divider #(.DW(16), .VW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .dividend(dividend), .divisor(divisor), .gotResult(gotResult),
    .busy(busy), .done(done), .Q(Q), .R(R),
    .divByZero(divByZero), .ov(ov)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #12;
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b want 0", busy); end
    nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL reset_done got %b want 0", done); end
    nchk++; if ({Q, R} !== 16'h0000) begin nfail++; $display("FAIL reset_QR got %h want 0000", {Q, R}); end
    nchk++; if ({divByZero, ov} !== 2'b00) begin nfail++; $display("FAIL reset_flags got %b want 00", {divByZero, ov}); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_idle_busy got %b want 0", busy); end
  endtask

  // Edges are counted including the one that samples start.
  task automatic test_divide(input string name, input logic m, input logic [15:0] dvd,
                             input logic [7:0] dvs, input logic [7:0] eq, input logic [7:0] er,
                             input logic edz, input logic eov, input int elat);
    int edges;
    logic saw_busy;
    @(negedge clk); start = 1'b1; mode = m; dividend = dvd; divisor = dvs;
    @(posedge clk); edges = 1; saw_busy = 1'b0;
    @(negedge clk); start = 1'b0;
    while (!done && edges < 100) begin
      saw_busy |= busy;
      @(posedge clk); edges++;
      @(negedge clk);
    end
    nchk++; if (edges !== elat) begin nfail++; $display("FAIL %s latency got %0d want %0d", name, edges, elat); end
    nchk++; if (!saw_busy) begin nfail++; $display("FAIL %s busy got never-high want high", name); end
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL %s busy_in_done got %b want 0", name, busy); end
    nchk++; if (Q !== eq) begin nfail++; $display("FAIL %s Q got %h want %h", name, Q, eq); end
    nchk++; if (R !== er) begin nfail++; $display("FAIL %s R got %h want %h", name, R, er); end
    nchk++; if (divByZero !== edz) begin nfail++; $display("FAIL %s divByZero got %b want %b", name, divByZero, edz); end
    nchk++; if (ov !== eov) begin nfail++; $display("FAIL %s ov got %b want %b", name, ov, eov); end
    gotResult = 1'b1;
    @(negedge clk); gotResult = 1'b0;
    nchk++; if (done !== 1'b0) begin nfail++; $display("FAIL %s release got done=%b want 0", name, done); end
  endtask

  // start pulses and gotResult while busy must not disturb the running division.
  task automatic test_ignore_start();
    int edges;
    @(negedge clk); start = 1'b1; mode = 1'b1; dividend = 16'd12345; divisor = 8'd100;
    @(posedge clk); edges = 1;
    @(negedge clk); start = 1'b0;
    while (!done && edges < 100) begin
      if (edges == 3 || edges == 6) begin
        start = 1'b1; dividend = 16'h0900; divisor = 8'd0; gotResult = 1'b1;
      end else begin
        start = 1'b0; gotResult = 1'b0;
      end
      @(posedge clk); edges++;
      @(negedge clk);
    end
    start = 1'b0; gotResult = 1'b0;
    nchk++; if (edges !== 11) begin nfail++; $display("FAIL ignore_start latency got %0d want 11", edges); end
    nchk++; if ({Q, R} !== {8'd123, 8'd45}) begin nfail++; $display("FAIL ignore_start QR got %0d/%0d want 123/45", Q, R); end
    nchk++; if ({divByZero, ov} !== 2'b00) begin nfail++; $display("FAIL ignore_start flags got %b want 00", {divByZero, ov}); end
    gotResult = 1'b1;
    @(negedge clk); gotResult = 1'b0;
  endtask

  task automatic test_hold_ack();
    int edges;
    @(negedge clk); start = 1'b1; mode = 1'b0; dividend = 16'hFEFF; divisor = 8'hFF;
    @(posedge clk); edges = 1;
    @(negedge clk); start = 1'b0;
    while (!done && edges < 100) begin
      @(posedge clk); edges++;
      @(negedge clk);
    end
    nchk++; if (done !== 1'b1) begin nfail++; $display("FAIL hold_reach_done got %b want 1", done); end
    repeat (5) @(negedge clk);
    nchk++; if (done !== 1'b1) begin nfail++; $display("FAIL hold_done got %b want 1", done); end
    nchk++; if ({Q, R} !== 16'hFFFE) begin nfail++; $display("FAIL hold_QR got %h want fffe", {Q, R}); end
    // simultaneous ack and start: back to IDLE, no new division
    gotResult = 1'b1; start = 1'b1; dividend = 16'h0100; divisor = 8'd2;
    @(negedge clk); gotResult = 1'b0; start = 1'b0;
    nchk++; if ({busy, done} !== 2'b00) begin nfail++; $display("FAIL ack_start_state got busy,done=%b want 00", {busy, done}); end
    repeat (2) @(negedge clk);
    nchk++; if (busy !== 1'b0) begin nfail++; $display("FAIL ack_start_nocapture got busy=%b want 0", busy); end
    nchk++; if ({Q, R} !== 16'hFFFE) begin nfail++; $display("FAIL idle_hold_QR got %h want fffe", {Q, R}); end
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk); start = 1'b1; mode = 1'b0; dividend = 16'd1000; divisor = 8'd7;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    nchk++; if (busy !== 1'b1) begin nfail++; $display("FAIL midcalc_busy got %b want 1", busy); end
    rst = 1'b0;
    #1;
    nchk++; if ({busy, done} !== 2'b00) begin nfail++; $display("FAIL midcalc_rst_state got %b want 00", {busy, done}); end
    nchk++; if ({Q, R} !== 16'h0000) begin nfail++; $display("FAIL midcalc_rst_QR got %h want 0000", {Q, R}); end
    nchk++; if ({divByZero, ov} !== 2'b00) begin nfail++; $display("FAIL midcalc_rst_flags got %b want 00", {divByZero, ov}); end
    @(negedge clk); rst = 1'b1;
    repeat (4) @(negedge clk);
    nchk++; if ({busy, done} !== 2'b00) begin nfail++; $display("FAIL midcalc_no_resume got %b want 00", {busy, done}); end
  endtask

  initial begin
    test_reset();
    test_divide("rest_1000_7",    1'b0, 16'd1000,  8'd7,   8'd142, 8'd6,  1'b0, 1'b0, 11);
    test_divide("nonrest_1000_7", 1'b1, 16'd1000,  8'd7,   8'd142, 8'd6,  1'b0, 1'b0, 11);
    test_divide("rest_feff",      1'b0, 16'hFEFF,  8'hFF,  8'hFF,  8'hFE, 1'b0, 1'b0, 11);
    test_divide("nonrest_feff",   1'b1, 16'hFEFF,  8'hFF,  8'hFF,  8'hFE, 1'b0, 1'b0, 11);
    test_divide("divzero",        1'b0, 16'h1234,  8'd0,   8'hFF,  8'h00, 1'b1, 1'b0, 2);
    test_divide("ovf",            1'b1, 16'h0900,  8'd5,   8'hFF,  8'h00, 1'b0, 1'b1, 2);
    test_divide("rest_12345_100", 1'b0, 16'd12345, 8'd100, 8'd123, 8'd45, 1'b0, 1'b0, 11);
    test_divide("nonrest_ff_1",   1'b1, 16'h00FF,  8'd1,   8'hFF,  8'h00, 1'b0, 1'b0, 11);
    test_divide("nonrest_13_200", 1'b1, 16'h0013,  8'd200, 8'd0,   8'd19, 1'b0, 1'b0, 11);
    test_ignore_start();
    test_hold_ack();
    test_reset_mid_calc();
    test_divide("after_reset",    1'b1, 16'd1000,  8'd7,   8'd142, 8'd6,  1'b0, 1'b0, 11);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/param_divider.md
PARAM_DIVIDER -- requirements
Module: param_divider

Interface
REQ-001 SHALL have parameter DW, default 16, dividend width (even, 4..32).
REQ-002 SHALL have parameter VW, default 8, divisor width (2..DW-2); quotient width QW = DW-VW.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-006 SHALL have port mode  input  1  algorithm select, sampled with start: 0 restoring, 1 non-restoring.
REQ-007 SHALL have port dividend  input  DW  unsigned dividend, sampled with start.
REQ-008 SHALL have port divisor  input  VW  unsigned divisor, sampled with start.
REQ-009 SHALL have port gotResult  input  1  consumer acknowledge of the result.
REQ-010 SHALL have port busy  output  1  high in LOAD, CALC and FIX.
REQ-011 SHALL have port done  output  1  high only in DONE.
REQ-012 SHALL have port Q  output  QW  quotient.
REQ-013 SHALL have port R  output  VW  remainder.
REQ-014 SHALL have port divByZero  output  1  registered error flag: latched divisor was zero.
REQ-015 SHALL have port ov  output  1  registered error flag: latched dividend[DW-1:QW] >= divisor, divisor nonzero.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, CALC, FIX and DONE.
REQ-017 IDLE with start=1 SHALL latch dividend, divisor and mode, and SHALL go to LOAD at the next edge; start outside IDLE SHALL be ignored.
REQ-018 In LOAD, if the latched divisor is 0, the block SHALL set divByZero=1, Q=all ones and R=0, and SHALL go to DONE.
REQ-019 In LOAD, otherwise, if the ov condition holds, the block SHALL set ov=1, Q=all ones and R=0, and SHALL go to DONE.
REQ-020 Otherwise LOAD SHALL set a VW+1-bit partial remainder A = dividend[DW-1:QW] and the quotient shift register = dividend[QW-1:0], clear the iteration counter, and go to CALC.
REQ-021 CALC SHALL run exactly QW cycles, producing one quotient bit per cycle, MSB first, via left shift of {A,Q}.
REQ-022 In restoring mode, each CALC cycle SHALL subtract the divisor from the shifted A; if the result is negative, A SHALL be restored and the bit is 0, otherwise the bit is 1.
REQ-023 In non-restoring mode, each CALC cycle SHALL subtract the divisor when the sign of A is 0 and add it when the sign is 1; the bit SHALL be the inverted new sign.
REQ-024 The A datapath SHALL be VW+1 bits wide two's complement; no CALC overflow is possible given REQ-019.
REQ-025 FIX SHALL last 1 cycle: in non-restoring mode with A negative, A SHALL be corrected by A+divisor; in restoring mode FIX SHALL pass A through unchanged.
REQ-026 FIX SHALL load R = A[VW-1:0] and go to DONE.
REQ-027 Latency SHALL be fixed: done rises QW+3 edges after the edge sampling start in the normal case, and 2 edges after it in the error case; the latency is mode-independent.
REQ-028 DONE SHALL hold Q, R, divByZero and ov stable until gotResult=1, then go to IDLE at that edge.
REQ-029 Q, R and the flags SHALL keep their last values in IDLE.
REQ-030 A new start SHALL clear divByZero and ov in LOAD.
REQ-031 gotResult outside DONE SHALL be ignored.
REQ-032 gotResult=1 and start=1 in the same DONE cycle SHALL return to IDLE only; start SHALL NOT be captured in that cycle.

Reset
REQ-033 rst=0 SHALL immediately force IDLE with busy, done, divByZero and ov at 0, and Q, R and internal registers at 0, including mid-CALC.
REQ-034 Operation SHALL resume only after rst=1 and a fresh start.

Verification
REQ-035 Defaults, mode=0, dividend=1000, divisor=7 -> done after 11 edges, Q=142, R=6, ov=0, divByZero=0.
REQ-036 Same operands with mode=1 -> identical Q=142, R=6 and latency 11.
REQ-037 dividend=0xFEFF, divisor=0xFF, both modes -> Q=0xFF, R=0xFE, no flags.
REQ-038 divisor=0 -> divByZero=1, Q=0xFF, R=0, done after 2 edges; dividend=0x0900, divisor=5 -> ov=1, Q=0xFF, R=0.
REQ-039 rst pulsed low during CALC cycle 4 -> outputs 0 immediately; start pulses during busy are ignored; results hold in DONE until gotResult, and a simultaneous start/gotResult does not begin a new division.
